// File: rtl/seg_bcd_formatter.sv
// Binary-to-4-digit display code formatter: double-dabble with one shift per clock, then one format cycle; done follows the load edge by VALUE_W+1 edges.
// No backpressure: load is only honoured in IDLE, and requests arriving while busy are dropped.
module seg_bcd_formatter #(
  parameter int VALUE_W   = 14,
  parameter int MAX_VALUE = 9999
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               blank_lz,
  input  logic [3:0]         dp_sel,
  output logic [4:0]         digit0,
  output logic [4:0]         digit1,
  output logic [4:0]         digit2,
  output logic [4:0]         digit3,
  output logic [3:0]         dp_out,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int CNT_W = (VALUE_W > 2) ? $clog2(VALUE_W) : 1;
  localparam logic [VALUE_W-1:0] MAX_V   = VALUE_W'(MAX_VALUE);
  localparam logic [CNT_W-1:0]   LAST    = CNT_W'(VALUE_W - 1);
  localparam logic [4:0]         C_BLANK = 5'd10;
  localparam logic [4:0]         C_ERR   = 5'd11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FORMAT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [VALUE_W-1:0] bin_q;
  logic [15:0]        bcd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               blz_q;
  logic [3:0]         dp_q;
  logic               ovf_q;

  logic [15:0]         bcd_adj;
  logic [15+VALUE_W:0] shift_vec;
  logic [15:0]         bcd_nx;
  logic [VALUE_W-1:0]  bin_nx;
  logic [4:0]          fmt [4];
  logic [3:0]          fmt_dp;
  logic                lz_run;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = FORMAT;
      FORMAT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Double-dabble step: correct every nibble >= 5, then shift {bcd,bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shift_vec = {bcd_adj, bin_q} << 1;
    bcd_nx    = shift_vec[15+VALUE_W:VALUE_W];
    bin_nx    = shift_vec[VALUE_W-1:0];
  end

  // Final codes; blanking walks down from digit3 and stops at the first
  // nonzero or dp-marked digit, digit0 is always shown.
  always_comb begin
    for (int i = 0; i < 4; i++) fmt[i] = {1'b0, bcd_q[4*i +: 4]};
    fmt_dp = dp_q;
    lz_run = blz_q;
    for (int i = 3; i >= 1; i--) begin
      if (lz_run && (bcd_q[4*i +: 4] == 4'd0) && !dp_q[i]) fmt[i] = C_BLANK;
      else                                                 lz_run = 1'b0;
    end
    if (ovf_q) begin
      for (int i = 0; i < 4; i++) fmt[i] = C_ERR;
      fmt_dp = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      blz_q    <= 1'b0;
      dp_q     <= 4'd0;
      ovf_q    <= 1'b0;
      digit0   <= C_BLANK;
      digit1   <= C_BLANK;
      digit2   <= C_BLANK;
      digit3   <= C_BLANK;
      dp_out   <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            bin_q <= value;
            bcd_q <= '0;
            cnt_q <= '0;
            blz_q <= blank_lz;
            dp_q  <= dp_sel;
            ovf_q <= (value > MAX_V);
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          bin_q <= bin_nx;
          bcd_q <= bcd_nx;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        FORMAT: begin
          digit0   <= fmt[0];
          digit1   <= fmt[1];
          digit2   <= fmt[2];
          digit3   <= fmt[3];
          dp_out   <= fmt_dp;
          overflow <= ovf_q;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_bcd_formatter.sv
// Directed-vector bench for seg_bcd_formatter; inputs driven and outputs sampled on the falling edge.
module tb_seg_bcd_formatter;

  logic        clk;
  logic        rst_n;
  logic [13:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  dp_sel;
  logic [4:0]  digit0, digit1, digit2, digit3;
  logic [3:0]  dp_out;
  logic        busy, done, overflow;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  seg_bcd_formatter #(.VALUE_W(14), .MAX_VALUE(9999)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .load     (load),
    .blank_lz (blank_lz),
    .dp_sel   (dp_sel),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .dp_out   (dp_out),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] dig(input int d3, input int d2, input int d1, input int d0);
    return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
  endfunction

  function automatic logic [19:0] shown();
    return {digit3, digit2, digit1, digit0};
  endfunction

  // One-cycle load; inj>0 re-requests value 42 on that busy cycle.
  task automatic convert(input int v, input logic blz, input logic [3:0] dp, input int inj,
                         output int lat, output int busy_cyc);
    int  n;
    bit  got;
    @(negedge clk);
    value = 14'(v); blank_lz = blz; dp_sel = dp; load = 1'b1;
    n = 0; got = 0; busy_cyc = 0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) load = 1'b0;
      if (inj > 0 && n == inj)     begin value = 14'd42; load = 1'b1; end
      if (inj > 0 && n == inj + 1) load = 1'b0;
      if (done) got = 1;
      else if (busy) busy_cyc++;
    end
    if (!got) check_eq("done_timeout", 0, 1);
    lat = n - 1;
    @(negedge clk);
    check_eq("done_one_cycle", {31'd0, done}, 0);
  endtask

  initial begin
    int lat, bc, dc0, n, gap;
    rst_n = 1'b0; value = '0; load = 1'b0; blank_lz = 1'b0; dp_sel = 4'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_digits", {12'd0, shown()}, {12'd0, dig(10, 10, 10, 10)});
    check_eq("rst_flags", {28'd0, busy, done, overflow, 1'b0}, 0);
    check_eq("rst_dp", {28'd0, dp_out}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    convert(1234, 1'b0, 4'd0, 0, lat, bc);
    check_eq("1234_latency", lat, 15);
    check_eq("1234_busy_cycles", bc, 15);
    check_eq("1234_digits", {12'd0, shown()}, {12'd0, dig(1, 2, 3, 4)});
    check_eq("1234_ovf", {31'd0, overflow}, 0);

    convert(7, 1'b1, 4'd0, 0, lat, bc);
    check_eq("7_blank", {12'd0, shown()}, {12'd0, dig(10, 10, 10, 7)});
    check_eq("7_ovf", {31'd0, overflow}, 0);

    convert(5, 1'b1, 4'b0010, 0, lat, bc);
    check_eq("5_dp_stops_blank", {12'd0, shown()}, {12'd0, dig(10, 10, 0, 5)});
    check_eq("5_dp_out", {28'd0, dp_out}, 32'b0010);

    convert(12000, 1'b1, 4'b1111, 0, lat, bc);
    check_eq("12000_err", {12'd0, shown()}, {12'd0, dig(11, 11, 11, 11)});
    check_eq("12000_ovf", {31'd0, overflow}, 1);
    check_eq("12000_dp", {28'd0, dp_out}, 0);

    convert(9999, 1'b0, 4'd0, 0, lat, bc);
    check_eq("9999_digits", {12'd0, shown()}, {12'd0, dig(9, 9, 9, 9)});
    check_eq("9999_ovf", {31'd0, overflow}, 0);

    convert(10000, 1'b0, 4'd0, 0, lat, bc);
    check_eq("10000_ovf", {31'd0, overflow}, 1);
    check_eq("10000_err", {12'd0, shown()}, {12'd0, dig(11, 11, 11, 11)});

    convert(16383, 1'b0, 4'd0, 0, lat, bc);
    check_eq("16383_ovf", {31'd0, overflow}, 1);

    convert(0, 1'b1, 4'd0, 0, lat, bc);
    check_eq("0_blank", {12'd0, shown()}, {12'd0, dig(10, 10, 10, 0)});
    convert(0, 1'b0, 4'd0, 0, lat, bc);
    check_eq("0_noblank", {12'd0, shown()}, {12'd0, dig(0, 0, 0, 0)});

    convert(1005, 1'b1, 4'd0, 0, lat, bc);
    check_eq("1005_inner_zeros", {12'd0, shown()}, {12'd0, dig(1, 0, 0, 5)});
    convert(40, 1'b1, 4'b1000, 0, lat, bc);
    check_eq("40_dp3", {12'd0, shown()}, {12'd0, dig(0, 0, 4, 0)});
    check_eq("40_dp_out", {28'd0, dp_out}, 32'b1000);
    convert(3060, 1'b1, 4'b0101, 0, lat, bc);
    check_eq("3060_digits", {12'd0, shown()}, {12'd0, dig(3, 0, 6, 0)});
    check_eq("3060_dp_out", {28'd0, dp_out}, 32'b0101);

    // load while busy is dropped
    dc0 = done_cnt;
    convert(1234, 1'b0, 4'd0, 5, lat, bc);
    repeat (20) @(negedge clk);
    check_eq("inject_done_count", done_cnt - dc0, 1);
    check_eq("inject_digits", {12'd0, shown()}, {12'd0, dig(1, 2, 3, 4)});
    check_eq("inject_latency", lat, 15);

    // load held high: restart on every return to IDLE
    @(negedge clk);
    value = 14'd321; blank_lz = 1'b1; dp_sel = 4'd0; load = 1'b1;
    n = 0;
    while (n < 40 && !done) begin @(negedge clk); n++; end
    check_eq("held_first_done", {31'd0, done}, 1);
    gap = 0;
    do begin @(negedge clk); gap++; end while (gap < 40 && !done);
    load = 1'b0;
    check_eq("held_gap", gap, 16);
    check_eq("held_digits", {12'd0, shown()}, {12'd0, dig(10, 3, 2, 1)});
    repeat (20) @(negedge clk);
    check_eq("held_idle", {31'd0, busy}, 0);

    // reset on 8th SHIFT cycle aborts without updating outputs
    @(negedge clk);
    value = 14'd1234; blank_lz = 1'b0; load = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) load = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_eq("abort_digits", {12'd0, shown()}, {12'd0, dig(10, 10, 10, 10)});
    check_eq("abort_busy", {31'd0, busy}, 0);
    check_eq("abort_done", {31'd0, done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dc0 = done_cnt;
    repeat (20) @(negedge clk);
    check_eq("abort_no_done", done_cnt - dc0, 0);
    check_eq("abort_still_blank", {12'd0, shown()}, {12'd0, dig(10, 10, 10, 10)});

    convert(5678, 1'b0, 4'd0, 0, lat, bc);
    check_eq("post_reset_digits", {12'd0, shown()}, {12'd0, dig(5, 6, 7, 8)});
    check_eq("post_reset_latency", lat, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
